softmax_writeback: RTL and testbench

Downstream stage of the softmax block. Accepts the NUM-lane result vector that softmax produces, buffers it in a small FIFO, and writes it word-by-word into the output on-chip RAM from out_start_addr to out_end_addr inclusive. Reports done when the last word has been committed. Decouples softmax output timing from RAM write availability (mem_ready).

---
 rtl/softmax_writeback_pkg.sv | 19 +
 rtl/softmax_wb_fifo.sv | 72 +++++++
 rtl/softmax_writeback.sv | 151 +++++++++++++++
 tb/tb_softmax_writeback.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_writeback_pkg.sv
// softmax_writeback_pkg
//   Shared definitions for the softmax write-back slice: default geometry
//   (element width, lanes per word, RAM address width, buffer depth) and the
//   control state encoding used by softmax_writeback.
//   Optional feature macro used by the slice: WB_CHECKSUM_EN.
package softmax_writeback_pkg;

    localparam int WB_DATAWIDTH  = 16;
    localparam int WB_NUM        = 4;
    localparam int WB_ADDRSIZE   = 10;
    localparam int WB_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/softmax_wb_fifo.sv
// softmax_wb_fifo
//   Synchronous FIFO holding whole softmax result vectors between the
//   softmax core and the RAM write port. The head entry is read
//   combinationally from registered storage, so a word pushed at cycle N is
//   visible at the head no earlier than cycle N+1.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset (empties the FIFO)
//   clear  - synchronous clear (empties the FIFO)
//   push   - write wdata (ignored when full)
//   pop    - drop head entry (ignored when empty)
//   wdata  - entry to write
//   rdata  - current head entry
//   full   - no free entry
//   empty  - no valid entry
module softmax_wb_fifo
    import softmax_writeback_pkg::*;
#(
    parameter int WIDTH = WB_DATAWIDTH * WB_NUM,
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/softmax_writeback.sv
// softmax_writeback
//   Takes NUM-lane softmax result vectors, buffers them, and writes them one
//   word per commit into on-chip RAM from out_start_addr to out_end_addr
//   inclusive (wrapping through address 0 if end < start). Signals done once
//   the last word has been committed.
//   Optional: define WB_CHECKSUM_EN to add the checksum output (XOR of every
//   lane of every committed word since the last start).
// Ports:
//   clk, reset(async active-low), init(sync clear), start(pulse)
//   out_start_addr/out_end_addr - inclusive RAM word range for the run
//   outp/outp_valid/outp_ready  - incoming result vectors (lane 0 in LSBs)
//   mem_addr/mem_d/mem_we/mem_ready - RAM write port, commit = mem_we&&mem_ready
//   busy - run in progress; done - run complete, held until start/init
//   checksum (WB_CHECKSUM_EN only)
module softmax_writeback
    import softmax_writeback_pkg::*;
#(
    parameter int DATAWIDTH  = WB_DATAWIDTH,
    parameter int NUM        = WB_NUM,
    parameter int ADDRSIZE   = WB_ADDRSIZE,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     start,
    input  logic [ADDRSIZE-1:0]      out_start_addr,
    input  logic [ADDRSIZE-1:0]      out_end_addr,
    input  logic [DATAWIDTH*NUM-1:0] outp,
    input  logic                     outp_valid,
    output logic                     outp_ready,
    output logic [ADDRSIZE-1:0]      mem_addr,
    output logic [DATAWIDTH*NUM-1:0] mem_d,
    output logic                     mem_we,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     done
`ifdef WB_CHECKSUM_EN
    ,
    output logic [DATAWIDTH-1:0]     checksum
`endif
);

    // One bit wider than the address so a full 2^ADDRSIZE-word run fits.
    localparam int CNT_W = ADDRSIZE + 1;

    wb_state_t                state;
    wb_state_t                state_nxt;
    logic [ADDRSIZE-1:0]      wr_addr;
    logic [CNT_W-1:0]         remaining;
    logic [CNT_W-1:0]         to_accept;
    logic [CNT_W-1:0]         span;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATAWIDTH*NUM-1:0] fifo_head;
    logic                     start_ok;
    logic                     push;
    logic                     commit;
    logic                     last_commit;

    assign span        = {1'b0, out_end_addr - out_start_addr} + CNT_W'(1);
    assign start_ok    = start && (state != RUN);
    // to_accept limits intake to exactly the words the run still needs.
    assign outp_ready  = (state == RUN) && !fifo_full && (to_accept != '0);
    assign push        = outp_valid && outp_ready;
    assign mem_we      = (state == RUN) && !fifo_empty;
    assign mem_addr    = wr_addr;
    // Gate data so the write bus reads zero whenever no write is offered.
    assign mem_d       = mem_we ? fifo_head : '0;
    assign commit      = mem_we && mem_ready;
    assign last_commit = commit && (remaining == CNT_W'(1));
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    softmax_wb_fifo #(
        .WIDTH (DATAWIDTH * NUM),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (init),
        .push  (push),
        .pop   (commit),
        .wdata (outp),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (last_commit) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (init) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_addr   <= '0;
            remaining <= '0;
            to_accept <= '0;
        end else begin
            state <= state_nxt;
            if (init) begin
                wr_addr   <= '0;
                remaining <= '0;
                to_accept <= '0;
            end else if (start_ok) begin
                wr_addr   <= out_start_addr;
                remaining <= span;
                to_accept <= span;
            end else begin
                if (commit) begin
                    wr_addr   <= wr_addr + ADDRSIZE'(1);
                    remaining <= remaining - CNT_W'(1);
                end
                if (push) begin
                    to_accept <= to_accept - CNT_W'(1);
                end
            end
        end
    end

`ifdef WB_CHECKSUM_EN
    function automatic logic [DATAWIDTH-1:0] lane_xor(input logic [DATAWIDTH*NUM-1:0] w);
        logic [DATAWIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM; i++) begin
            acc = acc ^ w[i*DATAWIDTH +: DATAWIDTH];
        end
        return acc;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (init || start_ok) begin
            checksum <= '0;
        end else if (commit) begin
            checksum <= checksum ^ lane_xor(mem_d);
        end
    end
`endif

endmodule

// File: tb/tb_softmax_writeback.sv
// tb_softmax_writeback
//   Self-checking bench for softmax_writeback. Directed runs (basic, RAM
//   backpressure, excess input, address wrap, reset/init abort, checksum)
//   followed by randomized runs, all checked against a queue-based model of
//   the expected RAM write sequence. Build with WB_CHECKSUM_EN to cover the
//   checksum output.
module tb_softmax_writeback;

    localparam int DW    = 16;
    localparam int NL    = 4;
    localparam int AW    = 10;
    localparam int W     = DW * NL;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          init;
    logic          start;
    logic [AW-1:0] out_start_addr;
    logic [AW-1:0] out_end_addr;
    logic [W-1:0]  outp;
    logic          outp_valid;
    logic          outp_ready;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_d;
    logic          mem_we;
    logic          mem_ready;
    logic          busy;
    logic          done;
`ifdef WB_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    softmax_writeback dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .start          (start),
        .out_start_addr (out_start_addr),
        .out_end_addr   (out_end_addr),
        .outp           (outp),
        .outp_valid     (outp_valid),
        .outp_ready     (outp_ready),
        .mem_addr       (mem_addr),
        .mem_d          (mem_d),
        .mem_we         (mem_we),
        .mem_ready      (mem_ready),
        .busy           (busy),
        .done           (done)
`ifdef WB_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] fixed_q[$];
    logic [DW-1:0] last_xs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run from s..e inclusive. The model is simply the ordered list of
    // accepted vectors; the k-th commit must carry the k-th accepted vector
    // to address s+k (mod 2^AW). abort_at >= 0 aborts the run once that many
    // words were committed (abort_kind 0: reset, 1: init).
    task automatic run_case(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input int stall, input int ready_pct, input int valid_pct,
                            input int abort_at, input int abort_kind);
        int            n;
        int            acc;
        int            com;
        logic [W-1:0]  q[$];
        logic [DW-1:0] xs;
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        logic [W-1:0]  prev_d;
        logic [AW-1:0] ea;
        bit            finished;
        n = ((int'(e) - int'(s)) & ((1 << AW) - 1)) + 1;
        acc = 0;
        com = 0;
        xs = '0;
        prev_stall = 1'b0;
        prev_addr = '0;
        prev_d = '0;
        finished = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_start_addr = s;
        out_end_addr = e;
        outp_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("no_write_empty", mem_we, 0);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (abort_at >= 0 && com == abort_at) begin
                outp_valid = 1'b0;
                if (abort_kind == 0) begin
                    reset = 1'b0;
                    #1;
                end else begin
                    init = 1'b1;
                    @(negedge clk);
                    init = 1'b0;
                    #1;
                end
                chk("abort_we", mem_we, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_ready", outp_ready, 0);
                chk("abort_d", mem_d, 0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            outp_valid = ($urandom_range(99) < valid_pct);
            outp = (fixed_q.size() > acc) ? fixed_q[acc] : {$urandom, $urandom};
            mem_ready = (cyc >= stall) && ($urandom_range(99) < ready_pct);
            #1;
            if (com == n) begin
                chk("done_set", done, 1);
                chk("busy_clear", busy, 0);
                chk("we_after_done", mem_we, 0);
                chk("ready_after_done", outp_ready, 0);
`ifdef WB_CHECKSUM_EN
                chk("checksum", checksum, xs);
`endif
                last_xs = xs;
                finished = 1'b1;
            end else begin
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("mem_we", mem_we, (acc - com) > 0);
                chk("outp_ready", outp_ready, ((acc - com) < DEPTH) && (acc < n));
                if (prev_stall) begin
                    chk("hold_addr", mem_addr, prev_addr);
                    chk("hold_data", mem_d, prev_d);
                end
                if (mem_we && q.size() > 0) begin
                    ea = s + AW'(com);
                    chk("mem_addr", mem_addr, ea);
                    chk("mem_d", mem_d, q[0]);
                end
                prev_stall = mem_we && !mem_ready;
                prev_addr = mem_addr;
                prev_d = mem_d;
                if (mem_we && mem_ready && q.size() > 0) begin
                    for (int i = 0; i < NL; i++) xs = xs ^ q[0][i*DW +: DW];
                    void'(q.pop_front());
                    com++;
                end
                if (outp_valid && outp_ready) begin
                    q.push_back(outp);
                    acc++;
                end
            end
        end
        if (!finished) chk("run_timeout", 0, 1);
    endtask

    initial begin
        logic [AW-1:0] rs;
        logic [AW-1:0] re;
        reset = 1'b0;
        init = 1'b0;
        start = 1'b0;
        out_start_addr = '0;
        out_end_addr = '0;
        outp = '0;
        outp_valid = 1'b0;
        mem_ready = 1'b1;
        last_xs = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", outp_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_d", mem_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef WB_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        reset = 1'b1;
        @(negedge clk);
        outp_valid = 1'b1;
        #1;
        chk("idle_not_ready", outp_ready, 0);
        outp_valid = 1'b0;

        run_case(10'd0, 10'd3, 0, 100, 100, -1, 0);      // basic
        run_case(10'd10, 10'd17, 8, 100, 100, -1, 0);    // RAM backpressure
        run_case(10'd5, 10'd5, 0, 100, 100, -1, 0);      // single word, excess input
        run_case(10'd1022, 10'd1, 0, 100, 100, -1, 0);   // wrap through 0
        run_case(10'd0, 10'd5, 0, 100, 100, 2, 0);       // reset mid-run
        run_case(10'd0, 10'd1, 0, 100, 100, -1, 0);      // clean run after abort
        run_case(10'd20, 10'd27, 0, 70, 60, 3, 1);       // init mid-run
        run_case(10'd40, 10'd43, 0, 100, 100, -1, 0);

        fixed_q.push_back(64'h0001_0002_0004_0008);
        fixed_q.push_back(64'h0010_0000_0000_0000);
        run_case(10'd0, 10'd1, 0, 100, 100, -1, 0);
        chk("checksum_model", last_xs, 16'h001F);
        fixed_q.delete();

        for (int r = 0; r < 6; r++) begin
            rs = AW'($urandom);
            re = rs + AW'($urandom_range(11));
            run_case(rs, re, int'($urandom_range(5)), 20 + int'($urandom_range(80)),
                     20 + int'($urandom_range(80)), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
